// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: decode/execute/mem/wb pipe fields in, stall/flush/forward controls out.
// The slave side is the hazard controller; the master side is the core (or a testbench).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_use1;
    logic             i_id_use2;
    logic [4:0]       i_ex_rs1;
    logic [4:0]       i_ex_rs2;
    logic [4:0]       i_ex_RegDst;
    logic             i_ex_MemToReg;
    logic             i_ex_RegWrEn;
    logic [4:0]       i_mem_RegDst;
    logic             i_mem_RegWrEn;
    logic             i_mem_Access;
    logic             i_dmem_ready;
    logic             i_ctl_NextPC;
    logic [4:0]       i_wb_RegDst;
    logic             i_wb_RegWrEn;
    logic             o_fetch_stall;
    logic             o_decode_stall;
    logic             o_exec_stall;
    logic             o_decode_flush;
    logic             o_exec_flush;
    logic             o_mem_flush;
    logic [1:0]       o_fwd_a;
    logic [1:0]       o_fwd_b;
    logic [CNT_W-1:0] o_stall_cycles;
    logic             o_err;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_use1, i_id_use2,
        output i_ex_rs1, i_ex_rs2, i_ex_RegDst, i_ex_MemToReg, i_ex_RegWrEn,
        output i_mem_RegDst, i_mem_RegWrEn, i_mem_Access, i_dmem_ready, i_ctl_NextPC,
        output i_wb_RegDst, i_wb_RegWrEn,
        input  o_fetch_stall, o_decode_stall, o_exec_stall,
        input  o_decode_flush, o_exec_flush, o_mem_flush,
        input  o_fwd_a, o_fwd_b, o_stall_cycles, o_err
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_use1, i_id_use2,
        input  i_ex_rs1, i_ex_rs2, i_ex_RegDst, i_ex_MemToReg, i_ex_RegWrEn,
        input  i_mem_RegDst, i_mem_RegWrEn, i_mem_Access, i_dmem_ready, i_ctl_NextPC,
        input  i_wb_RegDst, i_wb_RegWrEn,
        output o_fetch_stall, o_decode_stall, o_exec_stall,
        output o_decode_flush, o_exec_flush, o_mem_flush,
        output o_fwd_a, o_fwd_b, o_stall_cycles, o_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage RV32I pipeline: stall/flush controls, operand forwarding
// selects and a data-memory wait FSM with a sticky timeout error and a stall-cycle counter.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(MAX_WAIT);
    localparam logic [WCNT_W-1:0] ERR_AT   = WCNT_W'(MAX_WAIT - 1);
    localparam logic [WCNT_W-1:0] W_ONE    = WCNT_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);

    typedef enum logic {
        RUN,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              err_q, err_d;

    logic              mem_wait;
    logic              load_use;
    logic              fetch_stall, decode_stall, exec_stall;
    logic              decode_flush, exec_flush, mem_flush;
    logic [1:0]        fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_dst,
        input logic       mem_we,
        input logic [4:0] wb_dst,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == rs)) begin
            sel = 2'b01;
        end else if (wb_we && (wb_dst != 5'd0) && (wb_dst == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Priority: data-memory wait freezes everything, then a redirect, then a load-use bubble.
    always_comb begin
        mem_wait = (state_q == RUN) ? (bus.i_mem_Access && !bus.i_dmem_ready)
                                    : !bus.i_dmem_ready;
        load_use = bus.i_ex_MemToReg && bus.i_ex_RegWrEn && (bus.i_ex_RegDst != 5'd0) &&
                   ((bus.i_id_use1 && (bus.i_id_rs1 == bus.i_ex_RegDst)) ||
                    (bus.i_id_use2 && (bus.i_id_rs2 == bus.i_ex_RegDst)));

        fetch_stall  = 1'b0;
        decode_stall = 1'b0;
        exec_stall   = 1'b0;
        decode_flush = 1'b0;
        exec_flush   = 1'b0;
        mem_flush    = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;

        if (!reset) begin
            if (mem_wait) begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
                exec_stall   = 1'b1;
            end else if (bus.i_ctl_NextPC) begin
                decode_flush = 1'b1;
                exec_flush   = 1'b1;
                mem_flush    = 1'b1;
            end else if (load_use) begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
                exec_flush   = 1'b1;
            end
            fwd_a = fwd_sel(bus.i_ex_rs1, bus.i_mem_RegDst, bus.i_mem_RegWrEn,
                            bus.i_wb_RegDst, bus.i_wb_RegWrEn);
            fwd_b = fwd_sel(bus.i_ex_rs2, bus.i_mem_RegDst, bus.i_mem_RegWrEn,
                            bus.i_wb_RegDst, bus.i_wb_RegWrEn);
        end
    end

    // The wait count includes the RUN cycle that first misses, so it equals consecutive stalled cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.i_mem_Access && !bus.i_dmem_ready) state_d = WAIT;
            WAIT:    if (bus.i_dmem_ready) state_d = RUN;
            default: state_d = RUN;
        endcase

        wait_cnt_d = '0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + W_ONE;
        end
        err_d = err_q || (mem_wait && (wait_cnt_q >= ERR_AT));

        stall_cnt_d = stall_cnt_q;
        if (fetch_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_fetch_stall  = fetch_stall;
    assign bus.o_decode_stall = decode_stall;
    assign bus.o_exec_stall   = exec_stall;
    assign bus.o_decode_flush = decode_flush;
    assign bus.o_exec_flush   = exec_flush;
    assign bus.o_mem_flush    = mem_flush;
    assign bus.o_fwd_a        = fwd_a;
    assign bus.o_fwd_b        = fwd_b;
    assign bus.o_stall_cycles = stall_cnt_q;
    assign bus.o_err          = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 16;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
        logic       chk_state;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    exp_t sb[$];
    int   checks;
    int   errors;
    logic [3:0] exp_cnt;
    logic       exp_err;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        hif.i_id_rs1      = 5'd0;
        hif.i_id_rs2      = 5'd0;
        hif.i_id_use1     = 1'b0;
        hif.i_id_use2     = 1'b0;
        hif.i_ex_rs1      = 5'd0;
        hif.i_ex_rs2      = 5'd0;
        hif.i_ex_RegDst   = 5'd0;
        hif.i_ex_MemToReg = 1'b0;
        hif.i_ex_RegWrEn  = 1'b0;
        hif.i_mem_RegDst  = 5'd0;
        hif.i_mem_RegWrEn = 1'b0;
        hif.i_mem_Access  = 1'b0;
        hif.i_dmem_ready  = 1'b0;
        hif.i_ctl_NextPC  = 1'b0;
        hif.i_wb_RegDst   = 5'd0;
        hif.i_wb_RegWrEn  = 1'b0;
    endtask

    task automatic setLoad(input logic [4:0] dst);
        hif.i_ex_RegDst   = dst;
        hif.i_ex_MemToReg = 1'b1;
        hif.i_ex_RegWrEn  = 1'b1;
    endtask

    // Inputs are already driven; record what this cycle must show, then advance one clock.
    task automatic applyStimulus(input string name, input logic [2:0] st, input logic [2:0] fl,
                                 input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.name      = name;
        e.st        = st;
        e.fl        = fl;
        e.fa        = fa;
        e.fb        = fb;
        e.err       = exp_err;
        e.chk_state = !reset;
        e.cnt       = exp_cnt;
        sb.push_back(e);
        if (reset) begin
            exp_cnt = 4'd0;
            exp_err = 1'b0;
        end else if (st[2] && exp_cnt != 4'hF) begin
            exp_cnt = exp_cnt + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [11:0] got;
        logic [11:0] want;
        got  = {hif.o_fetch_stall, hif.o_decode_stall, hif.o_exec_stall,
                hif.o_decode_flush, hif.o_exec_flush, hif.o_mem_flush, hif.o_fwd_a, hif.o_fwd_b};
        want = {e.st, e.fl, e.fa, e.fb};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s ctrl: got %b required %b", e.name, got, want);
        end
        if (e.chk_state) begin
            checks++;
            if (hif.o_stall_cycles !== e.cnt) begin
                errors++;
                $display("[TB] FAIL %s stall_cycles: got %0d required %0d",
                         e.name, hif.o_stall_cycles, e.cnt);
            end
            checks++;
            if (hif.o_err !== e.err) begin
                errors++;
                $display("[TB] FAIL %s err: got %b required %b", e.name, hif.o_err, e.err);
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 4'd0;
        exp_err = 1'b0;
        reset   = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;

        // Reset gates a live load-use hazard and forwarding match.
        setLoad(5'd5);
        hif.i_id_rs2 = 5'd5; hif.i_id_use2 = 1'b1;
        hif.i_mem_RegDst = 5'd3; hif.i_mem_RegWrEn = 1'b1; hif.i_ex_rs1 = 5'd3;
        applyStimulus("reset_gate", 3'b000, 3'b000, 2'b00, 2'b00);
        applyStimulus("reset_gate2", 3'b000, 3'b000, 2'b00, 2'b00);
        reset = 1'b0;
        clearInputs();
        applyStimulus("idle", 3'b000, 3'b000, 2'b00, 2'b00);

        setLoad(5'd5);
        hif.i_id_rs1 = 5'd3; hif.i_id_use1 = 1'b1;
        hif.i_id_rs2 = 5'd5; hif.i_id_use2 = 1'b1;
        applyStimulus("loaduse_rs2", 3'b110, 3'b010, 2'b00, 2'b00);
        clearInputs();
        applyStimulus("loaduse_gone", 3'b000, 3'b000, 2'b00, 2'b00);

        setLoad(5'd5);
        hif.i_id_rs2 = 5'd5; hif.i_id_use2 = 1'b0;
        applyStimulus("loaduse_nouse", 3'b000, 3'b000, 2'b00, 2'b00);
        setLoad(5'd0);
        hif.i_id_rs2 = 5'd0; hif.i_id_use2 = 1'b1;
        applyStimulus("loaduse_x0", 3'b000, 3'b000, 2'b00, 2'b00);
        clearInputs();
        setLoad(5'd9);
        hif.i_id_rs1 = 5'd9; hif.i_id_use1 = 1'b1;
        applyStimulus("loaduse_rs1", 3'b110, 3'b010, 2'b00, 2'b00);
        hif.i_ex_MemToReg = 1'b0;
        applyStimulus("alu_no_stall", 3'b000, 3'b000, 2'b00, 2'b00);

        clearInputs();
        hif.i_mem_RegDst = 5'd7; hif.i_mem_RegWrEn = 1'b1;
        hif.i_wb_RegDst = 5'd7; hif.i_wb_RegWrEn = 1'b1;
        hif.i_ex_rs1 = 5'd7;
        applyStimulus("fwd_mem_wins", 3'b000, 3'b000, 2'b01, 2'b00);
        hif.i_mem_RegWrEn = 1'b0;
        applyStimulus("fwd_wb", 3'b000, 3'b000, 2'b10, 2'b00);
        hif.i_ex_rs1 = 5'd8; hif.i_ex_rs2 = 5'd7;
        applyStimulus("fwd_wb_b", 3'b000, 3'b000, 2'b00, 2'b10);
        clearInputs();
        hif.i_mem_RegDst = 5'd0; hif.i_mem_RegWrEn = 1'b1;
        hif.i_wb_RegDst = 5'd0; hif.i_wb_RegWrEn = 1'b1;
        applyStimulus("fwd_x0", 3'b000, 3'b000, 2'b00, 2'b00);
        hif.i_mem_RegDst = 5'd4; hif.i_wb_RegDst = 5'd6;
        hif.i_ex_rs1 = 5'd4; hif.i_ex_rs2 = 5'd6;
        applyStimulus("fwd_both", 3'b000, 3'b000, 2'b01, 2'b10);

        clearInputs();
        setLoad(5'd5);
        hif.i_id_rs2 = 5'd5; hif.i_id_use2 = 1'b1;
        hif.i_ctl_NextPC = 1'b1;
        hif.i_mem_RegDst = 5'd7; hif.i_mem_RegWrEn = 1'b1; hif.i_ex_rs1 = 5'd7;
        applyStimulus("redirect_over_lu", 3'b000, 3'b111, 2'b01, 2'b00);

        clearInputs();
        hif.i_mem_Access = 1'b1; hif.i_dmem_ready = 1'b1;
        applyStimulus("mem_ready_now", 3'b000, 3'b000, 2'b00, 2'b00);

        hif.i_dmem_ready = 1'b0; hif.i_ctl_NextPC = 1'b1;
        hif.i_mem_RegDst = 5'd7; hif.i_mem_RegWrEn = 1'b1; hif.i_ex_rs1 = 5'd7;
        for (int i = 0; i < 3; i++) applyStimulus("memwait3", 3'b111, 3'b000, 2'b01, 2'b00);
        hif.i_dmem_ready = 1'b1;
        applyStimulus("memwait_release", 3'b000, 3'b111, 2'b01, 2'b00);
        clearInputs();
        applyStimulus("after_release", 3'b000, 3'b000, 2'b00, 2'b00);

        hif.i_mem_Access = 1'b1;
        for (int i = 0; i < MAX_WAIT - 1; i++) applyStimulus("wait15", 3'b111, 3'b000, 2'b00, 2'b00);
        hif.i_dmem_ready = 1'b1;
        applyStimulus("wait15_release", 3'b000, 3'b000, 2'b00, 2'b00);
        clearInputs();
        applyStimulus("wait15_noerr", 3'b000, 3'b000, 2'b00, 2'b00);

        hif.i_mem_Access = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) applyStimulus("wait16", 3'b111, 3'b000, 2'b00, 2'b00);
        exp_err = 1'b1;
        applyStimulus("err_set_still_wait", 3'b111, 3'b000, 2'b00, 2'b00);
        hif.i_dmem_ready = 1'b1;
        applyStimulus("err_release", 3'b000, 3'b000, 2'b00, 2'b00);
        clearInputs();
        applyStimulus("err_sticky", 3'b000, 3'b000, 2'b00, 2'b00);

        hif.i_mem_Access = 1'b1;
        applyStimulus("pre_reset_wait", 3'b111, 3'b000, 2'b00, 2'b00);
        applyStimulus("pre_reset_wait2", 3'b111, 3'b000, 2'b00, 2'b00);
        reset = 1'b1;
        applyStimulus("reset_in_wait", 3'b000, 3'b000, 2'b00, 2'b00);
        reset = 1'b0;
        clearInputs();
        applyStimulus("post_reset_run", 3'b000, 3'b000, 2'b00, 2'b00);
        applyStimulus("post_reset_idle", 3'b000, 3'b000, 2'b00, 2'b00);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
